c4_input_cond: RTL
==================

# c4_input_cond

Two-channel input conditioner that sits directly upstream of the c4 state machine and drives its `a` and `c` inputs. Each raw switch/button input is passed through a two-flop synchroniser. It is then debounced by a per-channel stability counter, so that c4 only ever sees clean, glitch-free transitions. Channels are fully independent; only the clock and reset are shared.

## Interface

- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to accept a new level; legal range ≥ 2.
- Counter width is derived as ceil(log2(`DEBOUNCE_CYCLES`)); it is not a user parameter.

- `clk`  in  1  single system clock; all state updates on rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `a_raw`  in  1  unsynchronised, possibly bouncing input for channel A.
- `c_raw`  in  1  unsynchronised, possibly bouncing input for channel C.
- `a`  out  1  conditioned channel A, to c4 `a`.
- `c`  out  1  conditioned channel C, to c4 `c`.
- `busy`  out  1  high while either channel's counter is non-zero, i.e. a candidate transition is being qualified.

## Operation

- Per channel: `sync1 <= raw`, `sync2 <= sync1`, debounced state `db`, counter `cnt`.
- States per channel, encoded by (`db`, `cnt` == 0):
  - STABLE_LO / STABLE_HI: `sync2` == `db`, `cnt` = 0.
  - QUAL_HI / QUAL_LO: `sync2` != `db`, counting.
- Transitions, evaluated each edge:
  - `sync2` == `db`: `cnt` <= 0. A bounce abandons qualification with no partial credit.
  - `sync2` != `db` and `cnt` < `DEBOUNCE_CYCLES`-1: `cnt` <= `cnt`+1.
  - `sync2` != `db` and `cnt` == `DEBOUNCE_CYCLES`-1: commit. `db` <= `sync2`, `cnt` <= 0.
- `cnt` never wraps; it is cleared on commit or on a mismatch clearing.
- Output equals `db` (level mode) or a commit pulse (pulse mode; see Configuration). Outputs are registered, with no combinational path from raw inputs.
- `busy` = (`cnt_a` != 0) | (`cnt_c` != 0), registered-state derived.

## Timing

- Reset (`n_rst` low): `sync1`, `sync2`, `db`, `cnt` = 0 and `a`, `c`, `busy` = 0, immediately and independent of `clk`. This holds regardless of raw input levels.
- Reset release mid-qualification: all progress is lost. Qualification restarts from zero with full latency.
- Latency: the edge that first samples a new stable raw level is edge 1. The output changes after edge `DEBOUNCE_CYCLES`+2. For the default this is edge 6.
- A raw pulse that is stable for fewer than `DEBOUNCE_CYCLES` sampled cycles after synchronisation produces no output change.
- Simultaneous transitions on both channels produce output changes on the same edge. Neither channel delays the other.
- Raw held high through reset release is treated as a new rising transition. `db` rises at edge `DEBOUNCE_CYCLES`+2 after release, and in pulse mode it emits one pulse.
- Falling transitions have the same latency as rising ones.

## Configuration

- `C4_INPUT_PULSE_EN` not defined: `a`/`c` = debounced level `db`. They remain high as long as the input is accepted as high.
- `C4_INPUT_PULSE_EN` defined: `a`/`c` are high for exactly one clock cycle, on the same edge where `db` commits 0→1.
  - Falling commits produce no pulse.
  - A pulse never lasts more than one cycle, even if the input stays high.
  - `db`, `busy` and latency are unchanged.

## Test plan

- Reset: hold `n_rst`=0 with `a_raw`=`c_raw`=1 and toggle `clk` → `a`=`c`=`busy`=0 throughout. Assert `n_rst` low asynchronously between edges → outputs drop before the next edge.
- Clean edge, `DEBOUNCE_CYCLES`=4: `a_raw` 0→1 held → `busy`=1 from edge 3, `a`=1 after edge 6 and `busy`=0.
  - Level mode: `a` stays 1.
  - Pulse mode: `a`=1 for exactly one cycle.
  - Return `a_raw` to 0 → `a` (level mode) falls after edge 6 with no pulse.
- Bounce: `a_raw` = 1,1,1,0,1 then held high → no commit during the bounce. `a` rises after the 6th edge counted from the final 0→1.
- Glitch: `c_raw` high for 3 cycles then low → `c` never changes; `busy` returns to 0.
- Simultaneous: `a_raw` and `c_raw` rise on the same cycle → `a` and `c` change on the same edge.
- Reset mid-count: `a_raw` rises, assert `n_rst` low after edge 4, release, hold `a_raw` high → `a`=0 during reset, and `a` rises at edge 6 after release.

Source files
------------

// File: rtl/c4_input_cond.sv
// Two-channel input conditioner for c4: 2-flop synchroniser plus per-channel debounce counter.
// Define C4_INPUT_PULSE_EN to emit a one-cycle pulse on each accepted rising commit instead of the level.
module c4_input_cond #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic a_raw,
    input  logic c_raw,
    output logic a,
    output logic c,
    output logic busy
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0] w_raw;
    logic [1:0] w_out;
    logic [1:0] w_busy;

    assign w_raw = {c_raw, a_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic          r_sync1;
        logic          r_sync2;
        logic          r_db;
        logic [CW-1:0] r_cnt;
        logic          r_out;
        logic          w_commit;

        // Commit only after the mismatch has persisted for DEBOUNCE_CYCLES samples.
        assign w_commit = (r_sync2 != r_db) && (r_cnt == CNT_LAST);

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_db    <= 1'b0;
                r_cnt   <= '0;
                r_out   <= 1'b0;
            end else begin
                r_sync1 <= w_raw[ch];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_db) begin
                    r_cnt <= '0;
                end else if (w_commit) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
`ifdef C4_INPUT_PULSE_EN
                r_out <= w_commit && r_sync2;
`else
                r_out <= w_commit ? r_sync2 : r_db;
`endif
            end
        end

        assign w_out[ch]  = r_out;
        assign w_busy[ch] = (r_cnt != '0);
    end

    assign a    = w_out[0];
    assign c    = w_out[1];
    assign busy = |w_busy;

endmodule
